// File: rtl/b32p_isa_pkg.sv
// B32P instruction-format definitions shared by the encoder RTL and the decoder-side benches.
// Holds format encodings, field widths, the request payload and pack/range-check helpers.
package b32p_isa_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned REG_W     = 4;
    localparam int unsigned CONST16_W = 16;
    localparam int unsigned CONST27_W = 27;

    localparam logic [3:0] OP_ARITHC = 4'b0001;

    typedef enum logic [2:0] {
        FMT_ARITH  = 3'd0,
        FMT_ARITHC = 3'd1,
        FMT_C16    = 3'd2,
        FMT_C27    = 3'd3,
        FMT_BRANCH = 3'd4
    } fmt_e;

    typedef struct packed {
        logic [2:0]        fmt;
        logic [3:0]        op;
        logic [3:0]        aluop;
        logic [REG_W-1:0]  areg;
        logic [REG_W-1:0]  breg;
        logic [REG_W-1:0]  dreg;
        logic [WORD_W-1:0] cnst;
        logic [2:0]        bop;
        logic              flag;
    } enc_req_t;

    // A constant fits a field if it is zero-extended or sign-extended from the field width.
    function automatic logic const_legal(input enc_req_t r);
        logic fits16;
        logic fits27;
        fits16 = (r.cnst[WORD_W-1:CONST16_W] == '0) || (&r.cnst[WORD_W-1:CONST16_W-1]);
        fits27 = (r.cnst[WORD_W-1:CONST27_W] == '0) || (&r.cnst[WORD_W-1:CONST27_W-1]);
        case (r.fmt)
            FMT_ARITH:                        const_legal = 1'b1;
            FMT_ARITHC, FMT_C16, FMT_BRANCH:  const_legal = fits16;
            FMT_C27:                          const_legal = fits27;
            default:                          const_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] pack_word(input enc_req_t r);
        case (r.fmt)
            FMT_ARITH:  pack_word = {r.op, r.aluop, 12'h000, r.areg, r.breg, r.dreg};
            FMT_ARITHC: pack_word = {r.op, r.aluop, r.cnst[CONST16_W-1:0], r.areg, r.dreg};
            FMT_C16:    pack_word = {r.op, r.cnst[CONST16_W-1:0], r.areg[3:1],
                                     r.areg[0] | r.flag, r.breg, r.dreg};
            FMT_C27:    pack_word = {r.op, r.cnst[CONST27_W-1:0], r.flag};
            FMT_BRANCH: pack_word = {r.op, r.cnst[CONST16_W-1:0], r.areg, r.breg, r.bop, r.flag};
            default:    pack_word = '0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with combinational head read; full/empty come from an extra pointer wrap bit.
module instr_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/instruction_encoder.sv
// Streaming B32P instruction encoder: range-checks and packs requests into one pipeline
// stage, then queues encoded words in an output FIFO for the instruction-injection path.
module instruction_encoder
    import b32p_isa_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_fmt,
    input  logic [3:0]           in_op,
    input  logic [3:0]           in_aluop,
    input  logic [3:0]           in_areg,
    input  logic [3:0]           in_breg,
    input  logic [3:0]           in_dreg,
    input  logic [31:0]          in_const,
    input  logic [2:0]           in_bop,
    input  logic                 in_flag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_word,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [15:0]          word_count
);

    localparam int unsigned WCNT_W = 16;

    enc_req_t          req_c;
    logic              legal_c;
    logic [WORD_W-1:0] word_c;
    logic              accept_c;
    logic              s1_valid;
    logic [WORD_W-1:0] s1_word;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_head;
    logic [WORD_W-1:0] hold_word;

    assign req_c = '{fmt: in_fmt, op: in_op, aluop: in_aluop, areg: in_areg, breg: in_breg,
                     dreg: in_dreg, cnst: in_const, bop: in_bop, flag: in_flag};
    assign legal_c = const_legal(req_c);
    assign word_c  = pack_word(req_c);

    // S1 drains into the FIFO whenever a slot is free, including one freed by a same-cycle pop,
    // so a new request can be taken every clock without a bubble.
    assign fifo_pop  = !fifo_empty && out_ready;
    assign fifo_push = s1_valid && !flush && (!fifo_full || fifo_pop);
    assign in_ready  = !reset && !flush && (!s1_valid || fifo_push);
    assign accept_c  = in_valid && in_ready;

    assign out_valid = !fifo_empty;
    assign out_word  = fifo_empty ? hold_word : fifo_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_word    <= '0;
            hold_word  <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (accept_c && legal_c) begin
                s1_valid <= 1'b1;
                s1_word  <= word_c;
            end else if (fifo_push) begin
                s1_valid <= 1'b0;
            end

            // Remember the head so out_word keeps its last value once the FIFO runs dry.
            if (!fifo_empty) hold_word <= fifo_head;

            err_pulse <= accept_c && !legal_c;
            if (accept_c && !legal_c && (err_count != {ERR_CNT_W{1'b1}}))
                err_count <= err_count + ERR_CNT_W'(1);

            if (fifo_push) word_count <= word_count + WCNT_W'(1);
        end
    end

    instr_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (fifo_push),
        .wdata (s1_word),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
